// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one fifo input port among NUM_REQ producers.
// A grant lasts up to BURST_LEN beats. Each beat is tagged with the source ID.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 12,
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_rts,
   output logic [NUM_REQ-1:0]            req_rtr,
   output logic [DATA_WIDTH+ID_WIDTH-1:0] out_data,
   output logic                          out_rts,
   input  logic                          out_rtr,
   output logic                          grant_valid,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic [CNT_WIDTH-1:0]          beat_cnt
);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e               state_q, state_d;
   logic [ID_WIDTH-1:0]  grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

   logic [ID_WIDTH-1:0]  pick;
   logic                 pick_vld;
   logic                 out_xfc;
   logic                 in_grant;
   int                   idx;

   assign in_grant    = (state_q == GRANT);
   assign grant_valid = in_grant;
   assign grant_id    = grant_id_q;
   assign beat_cnt    = beat_cnt_q;

   // Port path is purely combinational so a stalled fifo back-pressures the producer in the same cycle.
   assign out_rts  = in_grant & req_rts[grant_id_q];
   assign out_xfc  = out_rts & out_rtr;
   assign out_data = {grant_id_q, req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH]};

   always_comb begin
      req_rtr = '0;
      if (in_grant) req_rtr[grant_id_q] = out_rtr;
   end

   // Scan starts one past the last winner, which gives rotating priority.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant_q) + k) % NUM_REQ;
         if (!pick_vld && req_rts[idx]) begin
            pick     = ID_WIDTH'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d    = GRANT;
               grant_id_d = pick;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            // Yield when the owner goes quiet or its final beat is accepted.
            if (!req_rts[grant_id_q] ||
                (out_xfc && beat_cnt_q == CNT_WIDTH'(BURST_LEN - 1))) begin
               state_d      = IDLE;
               last_grant_d = grant_id_q;
               beat_cnt_d   = '0;
            end else if (out_xfc) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo input port among NUM_REQ producers, such as rasteriser, blitter and host-write engines. Each producer uses the same rts/rtr handshake as the fifo. A granted producer keeps the port for a burst of up to BURST_LEN beats, so its data stays contiguous. Every beat is tagged with the source ID so the consumer downstream of the fifo can demultiplex.

Parameters:
DATA_WIDTH, 12, payload width per requester
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, bits of requester ID, ceil(log2(NUM_REQ))
BURST_LEN, 4, maximum beats per grant (1..255)
CNT_WIDTH, 8, burst counter width

Ports:
clk  in  1  clock
rst_  in  1  reset, asynchronous, active-low
req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_rts  in  NUM_REQ  requester i ready to send
req_rtr  out  NUM_REQ  arbiter ready to receive from requester i
out_data  out  DATA_WIDTH+ID_WIDTH  {grant_id, selected payload}; drives fifo in_data
out_rts  out  1  drives fifo in_rts
out_rtr  in  1  fifo in_rtr
grant_valid  out  1  high in GRANT state
grant_id  out  ID_WIDTH  currently or last granted requester
beat_cnt  out  CNT_WIDTH  beats transferred in current grant (debug)

Behaviour:
- Definitions: out_xfc = out_rts & out_rtr; req_xfc[i] = req_rts[i] & req_rtr[i].
- States: IDLE and GRANT, registered.
- Reset values (async): state=IDLE, grant_id=0, last_grant=NUM_REQ-1, beat_cnt=0. Consequently grant_valid=0, out_rts=0, req_rtr=0.
- Reset mid-burst: all outputs return to reset values immediately. No partial-beat side effects, because the fifo only writes on in_xfc.
- IDLE:
  - out_rts=0 and all req_rtr=0.
  - If any req_rts is set, pick the first asserted index scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
  - Register that index into grant_id, clear beat_cnt, and go to GRANT on the next edge.
  - Arbitration latency is one cycle: earliest out_rts is the cycle after req_rts rises.
- GRANT, with g = grant_id:
  - out_rts = req_rts[g].
  - req_rtr[g] = out_rtr; req_rtr[j] = 0 for all j≠g. This path is combinational, with zero-cycle pass-through.
  - out_data = {g, req_data[g]}.
  - On out_xfc, beat_cnt increments.
- GRANT release, back to IDLE with last_grant<=g and beat_cnt<=0. Release occurs when either:
  - (a) out_xfc occurs and beat_cnt==BURST_LEN-1; or
  - (b) req_rts[g]==0, regardless of out_rtr. The requester has gone idle, so the grant is yielded even below BURST_LEN.
- Fifo full (out_rtr=0) with req_rts[g]=1: hold GRANT indefinitely; beat_cnt and grant_id do not change.
- Requester contract: data must be held stable while rts=1 and rtr=0. The arbiter does not register payload.
- Each release costs one idle cycle (the IDLE re-arbitration cycle). Sustained throughput with all requesters busy is BURST_LEN/(BURST_LEN+1).
- Fairness: no requester can be granted twice while another requester holds rts continuously. Wrap-around from NUM_REQ-1 goes to 0.
- A grant change never occurs mid-cycle. grant_id changes only on the IDLE→GRANT edge.

Test Plan:
1. Reset, then req_rts=4'b0100 with out_rtr=1. Required: cycle 1 grant_id=2, grant_valid=1; 4 beats transfer with out_data[13:12]=2; back to IDLE after beat_cnt reaches 3.
2. All req_rts=4'b1111 continuously, out_rtr=1, 40 cycles. Required: grant order 0,1,2,3,0,…; each grant is exactly 4 beats followed by 1 idle cycle; 32 beats total.
3. Requester 1 alone drops rts after 2 beats. Required: release with beat_cnt=2, last_grant=1; a subsequent req_rts=4'b0011 grants 0 before 1.
4. In GRANT, hold out_rtr=0 for 10 cycles with rts held. Required: out_rts=1 and req_rtr=0 throughout, beat_cnt frozen, no state change; the burst resumes once out_rtr=1.
5. Assert rst_=0 mid-burst at beat_cnt=2. Required: out_rts=0, grant_valid=0 and req_rtr=0 immediately, before the next edge. After release with req_rts=4'b1111, grant_id=0 first.
6. Connect to a fifo with DEPTH=8 and a randomly stalled reader, 3 requesters sending sequence numbers. Required: per-ID sequence at the fifo output is in order, complete and has no duplicates.
